morse_letter_decoder: RTL

- Stage directly downstream of the button encoder. Consumes its per-press symbol pulses (dot/dash) plus the raw button level.
- Groups symbols into a letter by timing the inter-symbol silence, then decodes the letter to ASCII.
- Emits one character per letter, and a space (0x20) per word gap, through a 1-entry valid/ready output register feeding the display/UART stage.

---
 rtl/morse_letter_decoder.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/morse_letter_decoder.sv
// Morse letter decoder: groups dot/dash symbol pulses into letters by timing
// the silence after release, decodes each letter to ASCII, emits a space per
// word gap, and hands characters out through a 1-entry valid/ready register.
module morse_letter_decoder #(
    parameter int TICK_GAP_W = 5,
    parameter int LETTER_GAP = 6,
    parameter int WORD_GAP   = 14,
    parameter int MAX_SYM    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       button,
    input  logic       sym_valid,
    input  logic [1:0] sym_code,
    output logic [7:0] char_data,
    output logic       char_valid,
    input  logic       char_ready,
    output logic       bad_code,
    output logic       overrun,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_GAP     = 2'd2
    } state_e;

    // Pattern is at least 5 bits wide so the decode table always has its full key.
    localparam int PAT_W = (MAX_SYM > 5) ? MAX_SYM : 5;
    localparam logic [2:0]            LEN_OVF_C    = 3'(MAX_SYM + 1);
    localparam logic [TICK_GAP_W-1:0] LETTER_GAP_C = TICK_GAP_W'(LETTER_GAP);
    localparam logic [TICK_GAP_W-1:0] WORD_GAP_C   = TICK_GAP_W'(WORD_GAP);
    localparam logic [7:0]            CH_UNKNOWN   = 8'h3F;
    localparam logic [7:0]            CH_SPACE     = 8'h20;

    state_e                  state_q, state_d;
    logic [PAT_W-1:0]        pattern_q, pattern_d;
    logic [2:0]              len_q, len_d;
    logic [TICK_GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic                    word_pending_q, word_pending_d;
    logic [7:0]              char_data_q, char_data_d;
    logic                    char_valid_q, char_valid_d;
    logic                    bad_code_q, bad_code_d;
    logic                    overrun_q, overrun_d;

    logic       sym_is_dash;
    logic       sym_accept;
    logic       activity;
    logic       letter_done;
    logic       word_done;
    logic [7:0] decoded;

    // International Morse A-Z and 0-9; pattern is MSB-first, dot=0, dash=1.
    function automatic logic [7:0] decode_char(input logic [2:0] len, input logic [4:0] pat);
        logic [7:0] c;
        c = CH_UNKNOWN;
        case ({len, pat})
            {3'd2, 5'b00001}: c = 8'h41; // A .-
            {3'd4, 5'b01000}: c = 8'h42; // B -...
            {3'd4, 5'b01010}: c = 8'h43; // C -.-.
            {3'd3, 5'b00100}: c = 8'h44; // D -..
            {3'd1, 5'b00000}: c = 8'h45; // E .
            {3'd4, 5'b00010}: c = 8'h46; // F ..-.
            {3'd3, 5'b00110}: c = 8'h47; // G --.
            {3'd4, 5'b00000}: c = 8'h48; // H ....
            {3'd2, 5'b00000}: c = 8'h49; // I ..
            {3'd4, 5'b00111}: c = 8'h4A; // J .---
            {3'd3, 5'b00101}: c = 8'h4B; // K -.-
            {3'd4, 5'b00100}: c = 8'h4C; // L .-..
            {3'd2, 5'b00011}: c = 8'h4D; // M --
            {3'd2, 5'b00010}: c = 8'h4E; // N -.
            {3'd3, 5'b00111}: c = 8'h4F; // O ---
            {3'd4, 5'b00110}: c = 8'h50; // P .--.
            {3'd4, 5'b01101}: c = 8'h51; // Q --.-
            {3'd3, 5'b00010}: c = 8'h52; // R .-.
            {3'd3, 5'b00000}: c = 8'h53; // S ...
            {3'd1, 5'b00001}: c = 8'h54; // T -
            {3'd3, 5'b00001}: c = 8'h55; // U ..-
            {3'd4, 5'b00001}: c = 8'h56; // V ...-
            {3'd3, 5'b00011}: c = 8'h57; // W .--
            {3'd4, 5'b01001}: c = 8'h58; // X -..-
            {3'd4, 5'b01011}: c = 8'h59; // Y -.--
            {3'd4, 5'b01100}: c = 8'h5A; // Z --..
            {3'd5, 5'b11111}: c = 8'h30; // 0 -----
            {3'd5, 5'b01111}: c = 8'h31; // 1 .----
            {3'd5, 5'b00111}: c = 8'h32; // 2 ..---
            {3'd5, 5'b00011}: c = 8'h33; // 3 ...--
            {3'd5, 5'b00001}: c = 8'h34; // 4 ....-
            {3'd5, 5'b00000}: c = 8'h35; // 5 .....
            {3'd5, 5'b10000}: c = 8'h36; // 6 -....
            {3'd5, 5'b11000}: c = 8'h37; // 7 --...
            {3'd5, 5'b11100}: c = 8'h38; // 8 ---..
            {3'd5, 5'b11110}: c = 8'h39; // 9 ----.
            default:          c = CH_UNKNOWN;
        endcase
        return c;
    endfunction

    // Event decode: any activity (press or symbol, valid or not) beats a gap threshold.
    always_comb begin
        sym_is_dash = sym_valid && (sym_code == 2'b10);
        sym_accept  = sym_valid && ((sym_code == 2'b01) || (sym_code == 2'b10));
        activity    = button || sym_valid;
        letter_done = (state_q == ST_COLLECT) && (gap_cnt_q == LETTER_GAP_C) && !activity;
        word_done   = (state_q == ST_GAP) && word_pending_q && (gap_cnt_q == WORD_GAP_C) && !activity;
        decoded     = (len_q == LEN_OVF_C) ? CH_UNKNOWN : decode_char(len_q, pattern_q[4:0]);
    end

    // State register.
    // NOTE: sequential blocks use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (sym_accept) state_d = ST_COLLECT;
            ST_COLLECT: if (letter_done) state_d = ST_GAP;
            ST_GAP: begin
                if (sym_accept)     state_d = ST_COLLECT;
                else if (word_done) state_d = ST_IDLE;
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = (state_q == ST_COLLECT);
    end

    // Silence counter, symbol shift register and word-pending flag.
    always_comb begin
        gap_cnt_d      = gap_cnt_q;
        pattern_d      = pattern_q;
        len_d          = len_q;
        word_pending_d = word_pending_q;

        if (activity)
            gap_cnt_d = '0;
        else if (tick && (gap_cnt_q < WORD_GAP_C))
            gap_cnt_d = gap_cnt_q + TICK_GAP_W'(1);

        if (letter_done) begin
            pattern_d      = '0;
            len_d          = '0;
            word_pending_d = 1'b1;
        end else if (sym_accept) begin
            pattern_d = {pattern_q[PAT_W-2:0], sym_is_dash};
            len_d     = (len_q < LEN_OVF_C) ? len_q + 3'd1 : len_q;
        end

        if (word_done)
            word_pending_d = 1'b0;
    end

    // Output register: load when empty or being drained, otherwise drop and flag overrun.
    always_comb begin
        char_data_d  = char_data_q;
        char_valid_d = char_valid_q;
        bad_code_d   = letter_done && (decoded == CH_UNKNOWN);
        overrun_d    = 1'b0;

        if (char_valid_q && char_ready)
            char_valid_d = 1'b0;

        if (letter_done || word_done) begin
            if (!char_valid_q || char_ready) begin
                char_valid_d = 1'b1;
                char_data_d  = letter_done ? decoded : CH_SPACE;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern_q      <= '0;
            len_q          <= '0;
            gap_cnt_q      <= '0;
            word_pending_q <= 1'b0;
            char_data_q    <= 8'h00;
            char_valid_q   <= 1'b0;
            bad_code_q     <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            pattern_q      <= pattern_d;
            len_q          <= len_d;
            gap_cnt_q      <= gap_cnt_d;
            word_pending_q <= word_pending_d;
            char_data_q    <= char_data_d;
            char_valid_q   <= char_valid_d;
            bad_code_q     <= bad_code_d;
            overrun_q      <= overrun_d;
        end
    end

    assign char_data  = char_data_q;
    assign char_valid = char_valid_q;
    assign bad_code   = bad_code_q;
    assign overrun    = overrun_q;

endmodule
